// File: rtl/fetch_pkg.sv
// Shared defaults and the buffered-instruction record for the fetch queue.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH    = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head is read straight out
// of the storage flops so it holds steady until popped.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  // A pop frees a slot in the same cycle, so push is allowed at full when popping.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch into a small
// buffer, with redirect flushing and discard of stale in-flight responses.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = DEPTH[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0]   fetch_pc;
  // Address of the next response that will be kept: responses return in
  // order, so one running pointer replaces a FIFO of outstanding addresses.
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_aligned;
  logic [AW:0]   inflight, drop, fifo_count;
  logic [AW+1:0] credit_used;
  logic          req_fire, resp_ok, resp_keep;
  fetch_entry_t  wr_entry, head;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign credit_used      = {1'b0, fifo_count} + {1'b0, inflight};

  // Buffered plus outstanding entries may never exceed the buffer depth.
  assign imem_req_valid = rst && !redirect_valid && (credit_used < {1'b0, CAP});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is illegal and is ignored.
  assign resp_ok   = imem_resp_valid && (inflight != '0);
  assign resp_keep = resp_ok && !redirect_valid && (drop == '0);

  assign wr_entry = '{pc: resp_pc, instr: imem_resp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (resp_keep),
    .din   (wr_entry),
    .pop   (inst_ready),
    .dout  (head),
    .count (fifo_count)
  );

  assign inst_valid = (fifo_count != '0);
  assign inst_pc    = head.pc;
  assign inst_data  = head.instr;

  // Fetch/response pointers plus in-flight and to-be-dropped bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      resp_pc  <= {RESET_PC[31:2], 2'b00};
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // No request this cycle; everything still outstanding becomes stale,
      // and a response arriving now is already discarded.
      fetch_pc <= redirect_aligned;
      resp_pc  <= redirect_aligned;
      inflight <= inflight - {{AW{1'b0}}, resp_ok};
      drop     <= inflight - {{AW{1'b0}}, resp_ok};
    end else begin
      if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
      if (resp_keep) resp_pc  <= resp_pc + 32'd4;
      if (resp_ok && (drop != '0)) drop <= drop - ONE;
      case ({req_fire, resp_ok})
        2'b10:   inflight <= inflight + ONE;
        2'b01:   inflight <= inflight - ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: an in-order memory model with variable
// latency, and a reference model of the expected instruction stream.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_pc, inst_data;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data)
  );

  always #5 clk = ~clk;

  // Outstanding memory request; stale ones were overtaken by a redirect.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       memq[$];   // accepted, not yet answered (in order)
  logic [31:0] bufq[$];   // PCs the core should see next, in order
  logic [31:0] exp_req;   // next address the fetcher should request
  int          cyc;
  int          nvec;
  int          nerr;

  function automatic logic [31:0] mk_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %08h want %08h", tag, cyc, got, exp);
    end
  endtask

  // Called at a negedge. Holds reset for n cycles, checking reset values,
  // and returns at the negedge where reset is released.
  task automatic do_reset(input int n);
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b0;
    #1;
    chk("rst_req_valid",  {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr",   imem_req_addr, RESET_PC);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_pc",    inst_pc, 32'd0);
    chk("rst_inst_data",  inst_data, 32'd0);
    memq.delete();
    bufq.delete();
    exp_req = RESET_PC;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle, entered and left at a negedge.
  // Percent probabilities for request-ready, inst-ready and redirect.
  task automatic step(input int p_rdy, input int p_ird, input int p_rdr,
                      input int lat_lo, input int lat_hi);
    bit          rsp, rdr, hs, popv, keep, exp_v;
    logic [31:0] tgt, hs_addr;
    mreq_t       m;
    int          sel;

    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mk_data(memq[0].addr) : $urandom;
    imem_req_ready  = ($urandom_range(99) < p_rdy);
    inst_ready      = ($urandom_range(99) < p_ird);
    rdr             = ($urandom_range(99) < p_rdr);
    sel             = $urandom_range(3);
    tgt = (sel == 0) ? 32'h0000_0102 : (sel == 1) ? 32'hFFFF_FFF8 : $urandom;
    redirect_valid  = rdr;
    redirect_pc     = tgt;
    #1;

    exp_v = ((bufq.size() + memq.size()) < DEPTH) && !rdr;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_v});
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, bufq.size() != 0});
    if (inst_valid && bufq.size() != 0) begin
      chk("inst_pc",   inst_pc,   bufq[0]);
      chk("inst_data", inst_data, mk_data(bufq[0]));
    end
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    popv    = inst_valid && inst_ready;

    @(posedge clk);
    keep = 1'b0;
    if (rsp) begin
      m    = memq.pop_front();
      keep = !m.stale && !rdr;
    end
    if (popv && bufq.size() != 0) void'(bufq.pop_front());
    if (keep) bufq.push_back(m.addr);
    if (rdr) begin
      bufq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      exp_req = {tgt[31:2], 2'b00};
    end
    if (hs) begin
      m.addr  = hs_addr;
      m.due   = cyc + $urandom_range(lat_hi, lat_lo);
      m.stale = 1'b0;
      memq.push_back(m);
      exp_req = exp_req + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    @(negedge clk);
    do_reset(2);

    // Streaming: always ready, 1-cycle memory.
    repeat (30) step(100, 100, 0, 1, 1);
    // Core stalled: buffer fills and requests stop; then single pops.
    repeat (12) step(100, 0, 0, 1, 1);
    repeat (10) begin
      step(100, 100, 0, 1, 1);
      repeat (3) step(100, 0, 0, 1, 1);
    end
    // 3-cycle memory with redirects while requests are outstanding.
    repeat (60) step(100, 70, 10, 3, 3);
    // Reset with a full buffer, then restart from RESET_PC.
    repeat (10) step(100, 0, 0, 2, 2);
    do_reset(1);
    repeat (20) step(100, 100, 0, 1, 2);

    // Mixed random traffic with occasional resets.
    for (int seg = 0; seg < 20; seg++) begin
      int pr, pi, pd;
      pr = $urandom_range(100, 30);
      pi = $urandom_range(100, 0);
      pd = $urandom_range(25, 0);
      repeat (100) step(pr, pi, pd, 1, 4);
      if (seg % 7 == 6) do_reset($urandom_range(3, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
